exp2_div_pipe: RTL

Streaming inverse of the exp2 doubling pipeline. Each accepted word passes through DEPTH registered halving stages (logical right shift by 1 per stage) and emerges divided by 2^DEPTH, with a sticky flag reporting whether any set bit was shifted out. It sits on the receive side of the exp2 scaling path and recovers operands that the doubling pipeline scaled by 2^DEPTH. It also provides stall control and an occupancy count for the surrounding flow logic.

---
 rtl/exp2_pkg.sv | 23 ++
 rtl/exp2_half_stage.sv | 33 +++
 rtl/exp2_div_pipe.sv | 78 +++++++
 3 files changed

// File: rtl/exp2_pkg.sv
// Shared types for the exp2 halving pipeline: default sizes, stage record and
// the per-stage halving step.
package exp2_pkg;

    localparam int P_WIDTH = 100;
    localparam int P_DEPTH = 10;

    typedef struct packed {
        logic               valid;
        logic               inexact;
        logic [P_WIDTH-1:0] data;
    } stage_t;

    // Invalid records come out fully cleared so bubbles never carry stale data.
    function automatic stage_t halve(input stage_t s);
        stage_t r;
        r.valid   = s.valid;
        r.inexact = s.valid & (s.inexact | s.data[0]);
        r.data    = s.valid ? (s.data >> 1) : '0;
        return r;
    endfunction

endpackage

// File: rtl/exp2_half_stage.sv
// One registered halving stage: captures halve(stage_i) when enabled, holds
// otherwise.
module exp2_half_stage
    import exp2_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t stage_i,
    output stage_t stage_o
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d = halve(stage_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/exp2_div_pipe.sv
// Streaming divide-by-2^DEPTH pipeline with sticky inexact flag, stall enable
// and occupancy count. WIDTH must match exp2_pkg::P_WIDTH (stage_t width).
module exp2_div_pipe
    import exp2_pkg::*;
#(
    parameter int WIDTH = P_WIDTH,
    parameter int DEPTH = P_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_inexact,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       empty
);

    localparam int OW = $clog2(DEPTH+1);

    stage_t chain [DEPTH+1];
    stage_t tail;

    // The entry record has no sticky history; stage 0 performs the first halving.
    assign chain[0] = '{valid: in_valid, inexact: 1'b0, data: in_data};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        exp2_half_stage u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .stage_i (chain[k]),
            .stage_o (chain[k+1])
        );
    end

    assign tail = chain[DEPTH];

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    always_comb begin
        occ_d = occ_q;
        if (en) begin
            if (in_valid && !tail.valid) begin
                occ_d = occ_q + OW'(1);
            end else if (!in_valid && tail.valid) begin
                occ_d = occ_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid   = tail.valid;
    assign out_data    = tail.valid ? tail.data : '0;
    assign out_inexact = tail.valid & tail.inexact;
    assign occupancy   = occ_q;
    assign empty       = (occ_q == '0);

    a_occ_bound : assert property (@(posedge clk) disable iff (!rst)
        occ_q <= OW'(DEPTH));

    a_occ_underflow : assert property (@(posedge clk) disable iff (!rst)
        !(en && !in_valid && tail.valid && occ_q == '0));

    a_occ_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(en && in_valid && !tail.valid && occ_q == OW'(DEPTH)));

endmodule
